// File: rtl/pipe_stage_reg_if.sv
// Bundle of the upstream inputs, stage controls and registered outputs of one pipeline stage.
`default_nettype none

interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CTRL_W = 16
);
  logic [DATA_W-1:0] data_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic              valid_in;
  logic              halt_in;
  logic              hold;
  logic              bubble;
  logic              flush;

  logic [DATA_W-1:0] data_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic              valid_out;
  logic              halt_out;
  logic [15:0]       hold_cnt;
  logic [15:0]       bubble_cnt;

  modport master (
    output data_in, ctrl_in, valid_in, halt_in, hold, bubble, flush,
    input  data_out, ctrl_out, valid_out, halt_out, hold_cnt, bubble_cnt
  );

  modport slave (
    input  data_in, ctrl_in, valid_in, halt_in, hold, bubble, flush,
    output data_out, ctrl_out, valid_out, halt_out, hold_cnt, bubble_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg : pipeline stage register with flush/hold/bubble and stall counters
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg #(
  parameter int unsigned              DATA_W      = 16,
  parameter int unsigned              CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]        CTRL_MASK   = '1,
  parameter bit                       HALT_STICKY = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pipe_stage_reg_if.slave    bus
);

  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid;
  logic              r_halt;
  logic [15:0]       r_hold_cnt;
  logic [15:0]       r_bubble_cnt;

  logic              w_halt_keep;
  logic              w_hold_evt;
  logic              w_bubble_evt;

  // Value a halt falls back to when the stage is not loading a new halt.
  generate
    if (HALT_STICKY) begin : g_halt_sticky
      assign w_halt_keep = r_halt;
    end else begin : g_halt_plain
      assign w_halt_keep = 1'b0;
    end
  endgenerate

  assign w_hold_evt   = bus.hold & ~bus.flush;
  assign w_bubble_evt = bus.flush | (bus.bubble & ~bus.hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= '0;
      r_ctrl       <= '0;
      r_valid      <= 1'b0;
      r_halt       <= 1'b0;
      r_hold_cnt   <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (bus.flush) begin
        r_valid <= 1'b0;
        r_ctrl  <= r_ctrl & ~CTRL_MASK;
        r_halt  <= w_halt_keep;
      end else if (bus.hold) begin
        r_valid <= r_valid;
      end else if (bus.bubble) begin
        r_data  <= bus.data_in;
        r_ctrl  <= bus.ctrl_in & ~CTRL_MASK;
        r_valid <= 1'b0;
        r_halt  <= w_halt_keep;
      end else begin
        r_data  <= bus.data_in;
        r_ctrl  <= bus.valid_in ? bus.ctrl_in : (bus.ctrl_in & ~CTRL_MASK);
        r_valid <= bus.valid_in;
        r_halt  <= w_halt_keep | (bus.halt_in & bus.valid_in);
      end

      if (w_hold_evt && (r_hold_cnt != c_CNT_MAX)) begin
        r_hold_cnt <= r_hold_cnt + 16'd1;
      end
      if (w_bubble_evt && (r_bubble_cnt != c_CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end
  end

  assign bus.data_out   = r_data;
  assign bus.ctrl_out   = r_ctrl;
  assign bus.valid_out  = r_valid;
  assign bus.halt_out   = r_halt;
  assign bus.hold_cnt   = r_hold_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, reset/saturation sequences, randomized model compare.
`default_nettype none

module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] data_in  = '0;
  logic [15:0] ctrl_in  = '0;
  logic        valid_in = 1'b0;
  logic        halt_in  = 1'b0;
  logic        hold     = 1'b0;
  logic        bubble   = 1'b0;
  logic        flush    = 1'b0;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(16)) if_a ();
  pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(16)) if_b ();

  assign if_a.data_in = data_in;   assign if_b.data_in = data_in;
  assign if_a.ctrl_in = ctrl_in;   assign if_b.ctrl_in = ctrl_in;
  assign if_a.valid_in = valid_in; assign if_b.valid_in = valid_in;
  assign if_a.halt_in = halt_in;   assign if_b.halt_in = halt_in;
  assign if_a.hold = hold;         assign if_b.hold = hold;
  assign if_a.bubble = bubble;     assign if_b.bubble = bubble;
  assign if_a.flush = flush;       assign if_b.flush = flush;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .CTRL_MASK(16'h00F0), .HALT_STICKY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .CTRL_MASK(16'hFFFF), .HALT_STICKY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));

  typedef struct {
    logic [15:0] data;
    logic [15:0] ctrl;
    logic        valid;
    logic        halt;
    int          hcnt;
    int          bcnt;
  } st_t;

  typedef struct {
    logic        hold, bubble, flush, valid_in, halt_in;
    logic [15:0] din, cin;
    logic [15:0] edata, ectrl;
    logic        evalid, ehalt;
    logic [15:0] ehc, ebc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic h, input logic b, input logic f, input logic v,
                        input logic hi, input logic [15:0] d, input logic [15:0] c);
    hold = h; bubble = b; flush = f; valid_in = v; halt_in = hi; data_in = d; ctrl_in = c;
  endtask

  // Next state of a stage from its behavioural rules: which single action wins, then its effect.
  function automatic st_t model_step(input st_t s, input logic [15:0] mask, input bit sticky);
    st_t n = s;
    if (flush) begin
      n.valid = 1'b0;
      n.ctrl  = s.ctrl & ~mask;
      if (!sticky) n.halt = 1'b0;
      n.bcnt  = (s.bcnt + 1 > 65535) ? 65535 : s.bcnt + 1;
    end else if (hold) begin
      n.hcnt  = (s.hcnt + 1 > 65535) ? 65535 : s.hcnt + 1;
      if (bubble) n.bcnt = s.bcnt;
    end else if (bubble) begin
      n.data  = data_in;
      n.ctrl  = ctrl_in & ~mask;
      n.valid = 1'b0;
      n.halt  = sticky ? s.halt : 1'b0;
      n.bcnt  = (s.bcnt + 1 > 65535) ? 65535 : s.bcnt + 1;
    end else begin
      n.data  = data_in;
      n.ctrl  = valid_in ? ctrl_in : (ctrl_in & ~mask);
      n.valid = valid_in;
      n.halt  = (halt_in && valid_in) || (sticky && s.halt);
    end
    return n;
  endfunction

  task automatic chk_state(input string tag, input st_t e,
                           input logic [15:0] d, input logic [15:0] c, input logic v,
                           input logic h, input logic [15:0] hc, input logic [15:0] bc);
    chk({tag, ".data"},  d,  e.data);
    chk({tag, ".ctrl"},  c,  e.ctrl);
    chk({tag, ".valid"}, v,  e.valid);
    chk({tag, ".halt"},  h,  e.halt);
    chk({tag, ".hcnt"},  hc, e.hcnt[15:0]);
    chk({tag, ".bcnt"},  bc, e.bcnt[15:0]);
  endtask

  vec_t vecs[$];
  st_t  ma, mb, zero_st;

  initial begin
    zero_st = '{data: 16'h0, ctrl: 16'h0, valid: 1'b0, halt: 1'b0, hcnt: 0, bcnt: 0};

    // Directed table for the stage with CTRL_MASK=00F0, sticky halt.
    //                 h  b  f  v  hi din      cin      data     ctrl     v  h  hc  bc
    vecs.push_back('{0, 0, 0, 1, 0, 16'hAAAA, 16'h0F0F, 16'hAAAA, 16'h0F0F, 1, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 1, 1, 16'h5555, 16'hFFFF, 16'hAAAA, 16'h0F0F, 1, 0, 1, 0});
    vecs.push_back('{1, 1, 0, 1, 1, 16'h5555, 16'hFFFF, 16'hAAAA, 16'h0F0F, 1, 0, 2, 0});
    vecs.push_back('{1, 1, 0, 1, 1, 16'h5555, 16'hFFFF, 16'hAAAA, 16'h0F0F, 1, 0, 3, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 16'h1234, 16'h00FF, 16'h1234, 16'h00FF, 1, 0, 3, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 16'hBEEF, 16'h00FF, 16'hBEEF, 16'h000F, 0, 0, 3, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 16'hCAFE, 16'h00FF, 16'hCAFE, 16'h000F, 0, 0, 3, 1});
    vecs.push_back('{0, 0, 0, 1, 0, 16'h1111, 16'hFFFF, 16'h1111, 16'hFFFF, 1, 0, 3, 1});
    vecs.push_back('{1, 0, 1, 1, 0, 16'h2222, 16'h0000, 16'h1111, 16'hFF0F, 0, 0, 3, 2});
    vecs.push_back('{0, 0, 1, 1, 0, 16'h2222, 16'h0000, 16'h1111, 16'hFF0F, 0, 0, 3, 3});
    vecs.push_back('{0, 0, 0, 1, 1, 16'h3333, 16'h00F0, 16'h3333, 16'h00F0, 1, 1, 3, 3});
    vecs.push_back('{0, 0, 0, 1, 0, 16'h4444, 16'h0001, 16'h4444, 16'h0001, 1, 1, 3, 3});
    vecs.push_back('{0, 1, 0, 1, 0, 16'h5555, 16'h00FF, 16'h5555, 16'h000F, 0, 1, 3, 4});
    vecs.push_back('{0, 0, 1, 1, 0, 16'h5555, 16'h00FF, 16'h5555, 16'h000F, 0, 1, 3, 5});
    vecs.push_back('{0, 0, 0, 0, 1, 16'h6666, 16'h00F0, 16'h6666, 16'h0000, 0, 1, 3, 5});

    tick(); tick();
    chk_state("reset", zero_st, if_a.data_out, if_a.ctrl_out, if_a.valid_out,
              if_a.halt_out, if_a.hold_cnt, if_a.bubble_cnt);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      st_t e;
      set_in(vecs[i].hold, vecs[i].bubble, vecs[i].flush, vecs[i].valid_in,
             vecs[i].halt_in, vecs[i].din, vecs[i].cin);
      tick();
      e = '{data: vecs[i].edata, ctrl: vecs[i].ectrl, valid: vecs[i].evalid,
            halt: vecs[i].ehalt, hcnt: int'(vecs[i].ehc), bcnt: int'(vecs[i].ebc)};
      chk_state($sformatf("vec%0d", i), e, if_a.data_out, if_a.ctrl_out, if_a.valid_out,
                if_a.halt_out, if_a.hold_cnt, if_a.bubble_cnt);
    end

    // Asynchronous reset pulsed between edges while holding: outputs clear before any clock edge.
    set_in(1, 0, 0, 1, 1, 16'h7777, 16'h7777);
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", zero_st, if_a.data_out, if_a.ctrl_out, if_a.valid_out,
              if_a.halt_out, if_a.hold_cnt, if_a.bubble_cnt);
    #1 rst = 1'b0;
    set_in(0, 0, 0, 1, 1, 16'h8888, 16'h0F00);
    tick();
    chk_state("post_rst", '{data: 16'h8888, ctrl: 16'h0F00, valid: 1'b1, halt: 1'b1, hcnt: 0, bcnt: 0},
              if_a.data_out, if_a.ctrl_out, if_a.valid_out, if_a.halt_out, if_a.hold_cnt, if_a.bubble_cnt);

    // Randomized comparison of both stage variants against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ma = zero_st;
    mb = zero_st;
    for (int i = 0; i < 600; i++) begin
      logic r;
      r = ($urandom_range(0, 49) == 0);
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             16'($urandom), 16'($urandom));
      rst = r;
      if (r) begin
        ma = zero_st;
        mb = zero_st;
      end else begin
        ma = model_step(ma, 16'h00F0, 1'b1);
        mb = model_step(mb, 16'hFFFF, 1'b0);
      end
      tick();
      chk_state($sformatf("rndA%0d", i), ma, if_a.data_out, if_a.ctrl_out, if_a.valid_out,
                if_a.halt_out, if_a.hold_cnt, if_a.bubble_cnt);
      chk_state($sformatf("rndB%0d", i), mb, if_b.data_out, if_b.ctrl_out, if_b.valid_out,
                if_b.halt_out, if_b.hold_cnt, if_b.bubble_cnt);
    end
    rst = 1'b0;

    // Hold counter saturation over 65540 hold cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(1, 0, 0, 1, 0, 16'h0, 16'h0);
    for (int i = 1; i <= 65540; i++) begin
      tick();
      if (i == 65534) chk("hold_cnt_65534", if_a.hold_cnt, 16'hFFFE);
      if (i == 65535) chk("hold_cnt_65535", if_a.hold_cnt, 16'hFFFF);
    end
    chk("hold_cnt_sat_a", if_a.hold_cnt, 16'hFFFF);
    chk("hold_cnt_sat_b", if_b.hold_cnt, 16'hFFFF);
    chk("bubble_cnt_sat_a", if_a.bubble_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the datapath payload width in bits (1..64).
REQ-002 The block SHALL have parameter CTRL_W, default 16, meaning the control payload width in bits (1..32).
REQ-003 The block SHALL have parameter CTRL_MASK, default all ones (CTRL_W bits), meaning the control bits forced to 0 on bubble or flush (1 = clear, 0 = pass).
REQ-004 The block SHALL have parameter HALT_STICKY, default 1, meaning a captured halt holds until reset (1) or follows the loaded value (0).
REQ-005 The block SHALL have one clock and asynchronous active-high reset, with these ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have these input ports:
- data_in  in  DATA_W  payload from previous stage.
- ctrl_in  in  CTRL_W  control from previous stage.
- valid_in  in  1  previous stage holds a real instruction.
- halt_in  in  1  instruction is a halt.
- hold  in  1  freeze this stage (downstream stall).
- bubble  in  1  load data, insert NOP control (upstream hazard stall).
- flush  in  1  kill stage contents (branch/jump redirect).
REQ-007 The block SHALL have these output ports:
- data_out  out  DATA_W  registered payload.
- ctrl_out  out  CTRL_W  registered control.
- valid_out  out  1  registered valid.
- halt_out  out  1  registered halt.
- hold_cnt  out  16  saturating count of hold cycles.
- bubble_cnt  out  16  saturating count of bubble/flush insertions.

Function
REQ-008 The block SHALL evaluate each cycle in priority order flush > hold > bubble > load.
REQ-009 Flush SHALL apply on the next edge:
- valid_out <= 0.
- ctrl_out <= ctrl_out & ~CTRL_MASK.
- halt_out <= 0 when HALT_STICKY=0, otherwise unchanged.
- data_out unchanged.
REQ-010 Hold without flush SHALL leave data_out, ctrl_out, valid_out and halt_out unchanged.
REQ-011 Bubble without flush or hold SHALL apply on the next edge:
- data_out <= data_in.
- ctrl_out <= ctrl_in & ~CTRL_MASK.
- valid_out <= 0.
- halt_out loads 0 (or is unchanged when sticky and already 1).
REQ-012 Load, with no flush, hold or bubble, SHALL apply on the next edge:
- data_out <= data_in.
- ctrl_out <= ctrl_in when valid_in=1, else ctrl_in & ~CTRL_MASK.
- valid_out <= valid_in.
REQ-013 On load, halt_out SHALL become halt_in & valid_in; when HALT_STICKY=1 it becomes halt_out | (halt_in & valid_in).
REQ-014 Latency SHALL be exactly one cycle from input to output on load; there is no combinational path from any input to any output.
REQ-015 hold_cnt SHALL increment by 1 on each edge where hold=1 and flush=0, and saturate at 16'hFFFF.
REQ-016 bubble_cnt SHALL increment by 1 on each edge where flush=1, or bubble=1 and hold=0, and saturate at 16'hFFFF.
REQ-017 Simultaneous hold and bubble SHALL act as hold; bubble_cnt does not increment.
REQ-018 Simultaneous flush and hold SHALL act as flush; hold_cnt does not increment.
REQ-019 A counter at 16'hFFFF SHALL remain 16'hFFFF with no wrap.

Reset
REQ-020 Asserting rst SHALL immediately, without waiting for clk, set all outputs to 0: data_out, ctrl_out, valid_out, halt_out, hold_cnt, bubble_cnt.
REQ-021 Reset mid-operation, including during hold, SHALL discard all contents and counts; the first edge after rst deasserts follows REQ-008..REQ-019.

Verification
REQ-022 The bench SHALL cover load: DATA_W=16, data_in=16'h1234, ctrl_in=16'h00FF, valid_in=1, no controls -> one edge later data_out=16'h1234, ctrl_out=16'h00FF, valid_out=1.
REQ-023 The bench SHALL cover bubble with CTRL_MASK=16'h00F0: ctrl_in=16'h00FF, bubble=1 -> ctrl_out=16'h000F, valid_out=0, data_out=data_in, bubble_cnt=1.
REQ-024 The bench SHALL cover hold priority: stage holding 16'hAAAA, hold=1 and bubble=1 for 3 cycles with data_in=16'h5555 -> data_out stays 16'hAAAA, hold_cnt=3, bubble_cnt=0.
REQ-025 The bench SHALL cover flush over hold: flush=1 and hold=1 -> valid_out=0, masked ctrl cleared, data_out unchanged, bubble_cnt+1, hold_cnt unchanged.
REQ-026 The bench SHALL cover sticky halt: HALT_STICKY=1, load halt_in=1 valid_in=1, then load halt_in=0 -> halt_out stays 1 until rst; rst pulsed between clock edges -> all outputs 0 immediately.
REQ-027 The bench SHALL cover saturation: hold=1 held for 65540 cycles -> hold_cnt=16'hFFFF, no wrap.
